noc_pe_adapter: RTL and testbench



---
 rtl/noc_pe_adapter_pkg.sv | 23 ++
 rtl/noc_pe_adapter_sync_fifo.sv | 42 ++++
 rtl/noc_pe_adapter.sv | 159 +++++++++++++++
 tb/tb_noc_pe_adapter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pe_adapter_pkg.sv
// rtl/noc_pe_adapter_pkg.sv - shared flit layout helpers and TX FSM encoding
package noc_pe_adapter_pkg;

  // TX output register: nothing offered, or one flit held on the switch port
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  // Flit = {payload, dest_y, dest_x}, dest_x in the least significant bits
  function automatic int flit_width(input int xs, input int ys, input int dw);
    return xs + ys + dw;
  endfunction

  function automatic int y_lsb(input int xs);
    return xs;
  endfunction

  function automatic int payload_lsb(input int xs, input int ys);
    return xs + ys;
  endfunction

endpackage

// File: rtl/noc_pe_adapter_sync_fifo.sv
// rtl/noc_pe_adapter_sync_fifo.sv - single-clock FIFO with registered storage head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  // Extra pointer bit separates full from empty when the indices coincide
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Storage and pointers; a push while full is only issued together with a pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/noc_pe_adapter.sv
// rtl/noc_pe_adapter.sv - PE to mesh-switch network interface (TX pack/retry, RX buffer/unpack)
module noc_pe_adapter
  import noc_pe_adapter_pkg::*;
#(
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = flit_width(x_size, y_size, data_width),
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 8,
  parameter int STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_data,
  input  logic [x_size-1:0]      s_dest_x,
  input  logic [y_size-1:0]      s_dest_y,
  output logic                   noc_o_valid,
  input  logic                   noc_i_ready,
  output logic [total_width-1:0] noc_o_data,
  input  logic                   noc_i_valid,
  input  logic [total_width-1:0] noc_i_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [data_width-1:0]  m_data,
  output logic                   rx_overflow,
  output logic [7:0]             rx_drop_cnt,
  output logic                   tx_stall_err
);

  localparam int YL = y_lsb(x_size);
  localparam int PL = payload_lsb(x_size, y_size);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic                   rdy_q;
  logic                   tx_full, tx_empty, tx_push, tx_pop;
  logic [total_width-1:0] tx_head;
  tx_state_e              state_q, state_d;
  logic [total_width-1:0] flit_q, flit_d;
  logic [SW-1:0]          stall_q, stall_d;
  logic                   stall_err_q, stall_err_d;

  logic                   rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic                   overflow_q;
  logic [7:0]             drop_cnt_q;
  logic                   unused_rx_coord;

  // ---------------- TX path ----------------
  // rdy_q holds s_ready low during reset and for the release cycle
  assign s_ready = rdy_q & ~tx_full;
  assign tx_push = s_valid & s_ready;

  sync_fifo #(.WIDTH(total_width), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (tx_push),
    .wdata_i ({s_data, s_dest_y, s_dest_x}),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Output-register FSM and refused-cycle counter; the offer only changes on acceptance
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    stall_d = stall_q;
    tx_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        stall_d = '0;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          flit_d  = tx_head;
          state_d = TX_PEND;
        end
      end
      TX_PEND: begin
        if (noc_i_ready) begin
          stall_d = '0;
          if (!tx_empty) begin
            tx_pop = 1'b1;
            flit_d = tx_head;
          end else begin
            state_d = TX_IDLE;
          end
        end else if (stall_q != SW'(STALL_LIMIT)) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    stall_err_d = stall_err_q | (stall_d == SW'(STALL_LIMIT));
  end

  // TX state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q       <= 1'b0;
      state_q     <= TX_IDLE;
      flit_q      <= '0;
      stall_q     <= '0;
      stall_err_q <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      state_q     <= state_d;
      flit_q      <= flit_d;
      stall_q     <= stall_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign noc_o_valid  = (state_q == TX_PEND);
  assign noc_o_data   = flit_q;
  assign tx_stall_err = stall_err_q;

  // ---------------- RX path ----------------
  // A full FIFO still accepts when its head leaves in the same cycle
  assign rx_pop  = m_valid & m_ready;
  assign rx_push = noc_i_valid & (~rx_full | rx_pop);
  assign rx_drop = noc_i_valid & rx_full & ~rx_pop;

  sync_fifo #(.WIDTH(data_width), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (rx_push),
    .wdata_i (noc_i_data[total_width-1:PL]),
    .pop_i   (rx_pop),
    .rdata_o (m_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign m_valid = ~rx_empty;

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (rx_drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign rx_overflow = overflow_q;
  assign rx_drop_cnt = drop_cnt_q;

  // Delivered coordinates are not forwarded; the loopback compare is a diagnostic tap only
  assign unused_rx_coord = ^{noc_i_data[x_size-1:0] == x_size'(x_coord),
                             noc_i_data[PL-1:YL] == y_size'(y_coord)};

endmodule

// File: tb/tb_noc_pe_adapter.sv
// tb/tb_noc_pe_adapter.sv - self-checking bench for noc_pe_adapter
module tb_noc_pe_adapter;

  localparam int DW  = 32;
  localparam int XS  = 1;
  localparam int YS  = 1;
  localparam int TW  = XS + YS + DW;
  localparam int TXD = 4;
  localparam int RXD = 8;
  localparam int SL  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [XS-1:0] s_dest_x = '0;
  logic [YS-1:0] s_dest_y = '0;
  logic          noc_o_valid;
  logic          noc_i_ready = 1'b0;
  logic [TW-1:0] noc_o_data;
  logic          noc_i_valid = 1'b0;
  logic [TW-1:0] noc_i_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          rx_overflow;
  logic [7:0]    rx_drop_cnt;
  logic          tx_stall_err;

  always #5 clk = ~clk;

  noc_pe_adapter dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dest_x(s_dest_x), .s_dest_y(s_dest_y),
    .noc_o_valid(noc_o_valid), .noc_i_ready(noc_i_ready), .noc_o_data(noc_o_data),
    .noc_i_valid(noc_i_valid), .noc_i_data(noc_i_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rx_overflow(rx_overflow), .rx_drop_cnt(rx_drop_cnt), .tx_stall_err(tx_stall_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flits in flight (queue head is the one on offer), RX contents, flags
  logic [TW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  bit            ov_m, rdy_m, ovf_m, err_m;
  int            stall_m, drop_m;

  task automatic model_clear();
    txq.delete(); rxq.delete();
    ov_m = 0; rdy_m = 0; ovf_m = 0; err_m = 0; stall_m = 0; drop_m = 0;
  endtask

  // One clock: check current outputs against the model, drive inputs, advance the model
  task automatic cycle(input bit sv, input logic [DW-1:0] sd, input logic [XS-1:0] dx,
                       input logic [YS-1:0] dy, input bit nr, input bit niv,
                       input logic [DW-1:0] nip, input bit mr, output bit hs);
    bit exp_sr, pop, full;
    logic [XS+YS-1:0] crd;
    crd = (XS+YS)'($urandom);
    exp_sr = rdy_m && ((txq.size() - int'(ov_m)) < TXD);
    check("s_ready", s_ready, exp_sr);
    check("noc_o_valid", noc_o_valid, ov_m);
    if (ov_m) check("noc_o_data", noc_o_data, txq[0]);
    check("m_valid", m_valid, rxq.size() > 0);
    if (rxq.size() > 0) check("m_data", m_data, rxq[0]);
    check("rx_overflow", rx_overflow, ovf_m);
    check("rx_drop_cnt", rx_drop_cnt, drop_m);
    check("tx_stall_err", tx_stall_err, err_m);

    s_valid = sv; s_data = sd; s_dest_x = dx; s_dest_y = dy;
    noc_i_ready = nr; noc_i_valid = niv; noc_i_data = {nip, crd}; m_ready = mr;

    hs = sv && exp_sr;
    if (ov_m && !nr) begin
      stall_m++;
      if (stall_m >= SL) err_m = 1;
    end else begin
      stall_m = 0;
    end
    if (ov_m && nr) void'(txq.pop_front());
    ov_m = (txq.size() > 0);
    if (hs) txq.push_back({sd, dy, dx});
    full = (rxq.size() == RXD);
    pop  = mr && (rxq.size() > 0);
    if (pop) void'(rxq.pop_front());
    if (niv) begin
      if (!full || pop) rxq.push_back(nip);
      else begin
        ovf_m = 1;
        if (drop_m < 255) drop_m++;
      end
    end
    rdy_m = 1;
    @(posedge clk); #1;
  endtask

  // Assert reset between edges, check outputs clear at once, release after an edge
  task automatic do_reset();
    #3 rstn = 1'b0;
    #1;
    check("rst_noc_o_valid", noc_o_valid, 0);
    check("rst_noc_o_data", noc_o_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_rx_overflow", rx_overflow, 0);
    check("rst_rx_drop_cnt", rx_drop_cnt, 0);
    check("rst_tx_stall_err", tx_stall_err, 0);
    s_valid = 0; noc_i_ready = 0; noc_i_valid = 0; m_ready = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_clear();
  endtask

  typedef struct {
    bit            sv;
    logic [DW-1:0] sd;
    bit            dx, dy, nr, niv, mr;
    logic [TW-1:0] nid;
    bit            e_ov, e_sr, e_mv;
    logic [TW-1:0] e_od;
    logic [DW-1:0] e_md;
  } vec_t;

  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit hs, saw_full;
    int k;

    // sv sd dx dy nr niv mr nid | e_ov e_sr e_mv e_od e_md
    vt[0] = '{1, 32'hDEADBEEF, 1, 1, 1, 0, 0, '0,                     0, 1, 0, '0,            '0};
    vt[1] = '{0, '0,           0, 0, 1, 0, 0, '0,                     1, 1, 0, 34'h37AB6FBBF, '0};
    vt[2] = '{0, '0,           0, 0, 1, 0, 0, '0,                     0, 1, 0, '0,            '0};
    vt[3] = '{0, '0,           0, 0, 1, 1, 0, {32'h12345678, 2'b10},  0, 1, 1, '0,            32'h12345678};
    vt[4] = '{0, '0,           0, 0, 1, 1, 0, {32'hAAAA5555, 2'b01},  0, 1, 1, '0,            32'h12345678};
    vt[5] = '{0, '0,           0, 0, 1, 0, 1, '0,                     0, 1, 1, '0,            32'hAAAA5555};
    vt[6] = '{0, '0,           0, 0, 1, 0, 1, '0,                     0, 1, 0, '0,            '0};

    @(posedge clk); #1;
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, hs);

    // Single send and basic RX present/pop, one vector per clock
    for (int i = 0; i < 7; i++) begin
      s_valid = vt[i].sv; s_data = vt[i].sd; s_dest_x = vt[i].dx; s_dest_y = vt[i].dy;
      noc_i_ready = vt[i].nr; noc_i_valid = vt[i].niv; noc_i_data = vt[i].nid; m_ready = vt[i].mr;
      @(posedge clk); #1;
      check($sformatf("vec%0d_noc_o_valid", i), noc_o_valid, vt[i].e_ov);
      if (vt[i].e_ov) check($sformatf("vec%0d_noc_o_data", i), noc_o_data, vt[i].e_od);
      check($sformatf("vec%0d_s_ready", i), s_ready, vt[i].e_sr);
      check($sformatf("vec%0d_m_valid", i), m_valid, vt[i].e_mv);
      if (vt[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, vt[i].e_md);
    end

    // Backpressure: switch refuses 5 cycles while the PE pushes 6 flits
    k = 0; saw_full = 0;
    for (int c = 0; c < 18; c++) begin
      if (!s_ready && rdy_m) saw_full = 1;
      cycle(k < 6, 32'hC0DE0000 + DW'(k), k[0], k[1], c >= 5, 0, 0, 0, hs);
      if (hs) k++;
    end
    check("bp_all_pushed", k, 6);
    check("bp_s_ready_dropped", saw_full, 1);
    check("bp_all_drained", txq.size(), 0);

    // RX overflow: 9 flits into 8 entries with no consumer, then drain
    for (int i = 1; i <= 9; i++) cycle(0, 0, 0, 0, 1, 1, DW'(i), 0, hs);
    check("ovf_flag", rx_overflow, 1);
    check("ovf_drop_cnt", rx_drop_cnt, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, 0, 1, hs);
    check("ovf_drained", m_valid, 0);

    // Full FIFO with simultaneous pop and push: no drop, new payload last
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 1, 32'h100 + DW'(i), 0, hs);
    cycle(0, 0, 0, 0, 1, 1, 32'h1FF, 1, hs);
    check("fpp_drop_cnt", rx_drop_cnt, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, 0, 1, hs);
    check("fpp_drained", m_valid, 0);

    // Async reset while a flit is pending and both FIFOs hold data
    for (int i = 0; i < 4; i++) cycle(1, 32'hBAD0 + DW'(i), 1, 0, 0, i < 2, 32'hBEEF, 0, hs);
    check("ar_pending", noc_o_valid, 1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 0, 1, hs);

    // Stall watchdog: one flit refused for STALL_LIMIT cycles
    cycle(1, 32'h5EED, 0, 1, 0, 0, 0, 0, hs);
    for (int i = 0; i < 40 && stall_m < SL - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, hs);
    check("wd_not_yet", tx_stall_err, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, hs);
    check("wd_set", tx_stall_err, 1);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, hs);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, hs);
    check("wd_sticky", tx_stall_err, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), $urandom, XS'($urandom), YS'($urandom),
            $urandom_range(0, 9) < 7, 1'($urandom), $urandom, $urandom_range(0, 9) < 6, hs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
